// File: rtl/citadel_bridge_pkg.sv
// Shared definitions for the citadel command bridge: register offsets,
// STATUS bit positions and the command record sent to citadel_gen.
package citadel_bridge_pkg;

  // Register offsets within the 256-byte bus window
  localparam logic [7:0] OFF_CTRL       = 8'h00;
  localparam logic [7:0] OFF_EXEC       = 8'h04;
  localparam logic [7:0] OFF_RF_WE      = 8'h08;
  localparam logic [7:0] OFF_RF_ADDR    = 8'h0C;
  localparam logic [7:0] OFF_RF_WDATA   = 8'h10;
  localparam logic [7:0] OFF_FU_ID      = 8'h14;
  localparam logic [7:0] OFF_FU_OPCODE  = 8'h18;
  localparam logic [7:0] OFF_FU_RS0     = 8'h1C;
  localparam logic [7:0] OFF_FU_RS1     = 8'h20;
  localparam logic [7:0] OFF_FU_RS2     = 8'h24;
  localparam logic [7:0] OFF_FU_RD      = 8'h28;
  localparam logic [7:0] OFF_RDATA      = 8'h40;
  localparam logic [7:0] OFF_STATUS     = 8'h44;
  localparam logic [7:0] OFF_STATUS_CLR = 8'h48;

  // STATUS register layout
  localparam int ST_CMD_CNT_LSB  = 0;
  localparam int ST_RESP_CNT_LSB = 8;
  localparam int ST_CMD_OVF      = 16;
  localparam int ST_RESP_UDF     = 17;
  localparam int ST_CMD_FULL     = 18;
  localparam int ST_RESP_FULL    = 19;

  // Command record handed to citadel_gen (mirrors citadel_gen's command layout)
  typedef struct packed {
    logic        exec;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [3:0]  fu_id;
    logic [7:0]  fu_opcode;
    logic [4:0]  fu_rs0;
    logic        fu_rs0_req;
    logic [4:0]  fu_rs1;
    logic        fu_rs1_req;
    logic [4:0]  fu_rs2;
    logic        fu_rs2_req;
    logic [4:0]  fu_rd;
  } citadel_gen_cmd_req_struct;

  localparam int CMD_W = $bits(citadel_gen_cmd_req_struct);

endpackage

// File: rtl/citadel_cmd_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes into a full FIFO and pops
// from an empty FIFO are ignored. Head data is combinational from storage.
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_POW = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_POW:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_POW;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_POW-1:0] r_wr_ptr;
  logic [DEPTH_POW-1:0] r_rd_ptr;
  logic [DEPTH_POW:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  // Full/empty come from the registered count, so both reflect the start of the cycle
  assign full_o    = (r_count == (DEPTH_POW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  assign rdata_o   = r_mem[r_rd_ptr];

  // Storage is not reset; only entries behind a valid count are ever observed
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  // Pointers wrap naturally at DEPTH; count tracks push minus pop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/citadel_cmd_bridge.sv
// UDM bus slave that stages citadel_gen commands, queues them in a CMD FIFO,
// and buffers citadel_gen responses in a RESP FIFO popped through RDATA.
//
// Bus handshake: bus_ack_o mirrors bus_req_i in the same cycle for every
// request. A read hitting the window returns bus_resp_o high for exactly one
// cycle, one cycle after the request, with bus_rdata_bo valid in that cycle.
// genfifo handshakes: a transfer happens on a clock edge where req and ack are
// both high; req never depends on ack.
module citadel_cmd_bridge
  import citadel_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h10000000,
  parameter int          CMD_DEPTH_POW  = 2,
  parameter int          RESP_DEPTH_POW = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      bus_req_i,
  input  logic                      bus_we_i,
  input  logic [31:0]               bus_addr_bi,
  input  logic [3:0]                bus_be_bi,
  input  logic [31:0]               bus_wdata_bi,
  output logic                      bus_ack_o,
  output logic                      bus_resp_o,
  output logic [31:0]               bus_rdata_bo,
  output logic                      cmd_req_genfifo_req_o,
  output citadel_gen_cmd_req_struct cmd_req_genfifo_wdata_bo,
  input  logic                      cmd_req_genfifo_ack_i,
  input  logic                      cmd_resp_genfifo_req_i,
  input  logic [31:0]               cmd_resp_genfifo_rdata_bi,
  output logic                      cmd_resp_genfifo_ack_o
);

  // Staging registers
  logic        r_exec;
  logic        r_rf_we;
  logic [4:0]  r_rf_addr;
  logic [31:0] r_rf_wdata;
  logic [3:0]  r_fu_id;
  logic [7:0]  r_fu_opcode;
  logic [4:0]  r_fu_rs0;
  logic [4:0]  r_fu_rs1;
  logic [4:0]  r_fu_rs2;
  logic [4:0]  r_fu_rd;
  logic [2:0]  r_rs_req;   // {rs2_req, rs1_req, rs0_req}

  // Sticky errors and read response
  logic        r_cmd_ovf;
  logic        r_resp_udf;
  logic        r_resp;
  logic [31:0] r_rdata;

  // Decode
  logic        w_hit;
  logic [7:0]  w_offset;
  logic        w_wr;
  logic        w_rd;
  logic        w_cmd_issue;
  logic        w_status_clr;
  logic        w_rdata_rd;
  logic        w_unused_be;

  // FIFO plumbing
  citadel_gen_cmd_req_struct w_cmd_new;
  logic [CMD_W-1:0]          w_cmd_head;
  logic                      w_cmd_push;
  logic                      w_cmd_pop;
  logic                      w_cmd_full;
  logic                      w_cmd_empty;
  logic [CMD_DEPTH_POW:0]    w_cmd_cnt;
  logic [31:0]               w_resp_head;
  logic                      w_resp_push;
  logic                      w_resp_pop;
  logic                      w_resp_full;
  logic                      w_resp_empty;
  logic [RESP_DEPTH_POW:0]   w_resp_cnt;
  logic [31:0]               w_status;
  logic [31:0]               w_rdata_mux;

  // Byte enables carry no meaning here: every access is a full word
  assign w_unused_be = ^bus_be_bi;

  assign w_hit        = (bus_addr_bi[31:8] == BASE_ADDR[31:8]);
  assign w_offset     = bus_addr_bi[7:0];
  assign w_wr         = bus_req_i & bus_we_i & w_hit;
  assign w_rd         = bus_req_i & ~bus_we_i & w_hit;
  assign bus_ack_o    = bus_req_i;
  assign w_cmd_issue  = w_wr & (w_offset == OFF_CTRL) & bus_wdata_bi[0];
  assign w_status_clr = w_wr & (w_offset == OFF_STATUS_CLR);
  assign w_rdata_rd   = w_rd & (w_offset == OFF_RDATA);

  // Full is taken from the start of the cycle, so a same-cycle pop cannot rescue an issue
  assign w_cmd_push  = w_cmd_issue & ~w_cmd_full;
  assign w_cmd_pop   = cmd_req_genfifo_req_o & cmd_req_genfifo_ack_i;
  assign w_resp_push = cmd_resp_genfifo_req_i & cmd_resp_genfifo_ack_o;
  assign w_resp_pop  = w_rdata_rd & ~w_resp_empty;

  assign cmd_req_genfifo_req_o    = ~w_cmd_empty;
  assign cmd_req_genfifo_wdata_bo = w_cmd_head;
  assign cmd_resp_genfifo_ack_o   = ~w_resp_full;
  assign bus_resp_o               = r_resp;
  assign bus_rdata_bo             = r_rdata;

  // Command pushed on CTRL: current staging plus the rs_req bits being written now
  always_comb begin
    w_cmd_new            = '0;
    w_cmd_new.exec       = r_exec;
    w_cmd_new.rf_we      = r_rf_we;
    w_cmd_new.rf_addr    = r_rf_addr;
    w_cmd_new.rf_wdata   = r_rf_wdata;
    w_cmd_new.fu_id      = r_fu_id;
    w_cmd_new.fu_opcode  = r_fu_opcode;
    w_cmd_new.fu_rs0     = r_fu_rs0;
    w_cmd_new.fu_rs0_req = bus_wdata_bi[1];
    w_cmd_new.fu_rs1     = r_fu_rs1;
    w_cmd_new.fu_rs1_req = bus_wdata_bi[2];
    w_cmd_new.fu_rs2     = r_fu_rs2;
    w_cmd_new.fu_rs2_req = bus_wdata_bi[3];
    w_cmd_new.fu_rd      = r_fu_rd;
  end

  sync_fifo #(
    .WIDTH     (CMD_W),
    .DEPTH_POW (CMD_DEPTH_POW)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_cmd_push),
    .wdata_i (w_cmd_new),
    .pop_i   (w_cmd_pop),
    .rdata_o (w_cmd_head),
    .full_o  (w_cmd_full),
    .empty_o (w_cmd_empty),
    .count_o (w_cmd_cnt)
  );

  sync_fifo #(
    .WIDTH     (32),
    .DEPTH_POW (RESP_DEPTH_POW)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_resp_push),
    .wdata_i (cmd_resp_genfifo_rdata_bi),
    .pop_i   (w_resp_pop),
    .rdata_o (w_resp_head),
    .full_o  (w_resp_full),
    .empty_o (w_resp_empty),
    .count_o (w_resp_cnt)
  );

  // STATUS word assembly; counts are zero-extended into their byte lanes
  always_comb begin
    w_status = '0;
    w_status[ST_CMD_CNT_LSB +: 8]  = 8'(w_cmd_cnt);
    w_status[ST_RESP_CNT_LSB +: 8] = 8'(w_resp_cnt);
    w_status[ST_CMD_OVF]           = r_cmd_ovf;
    w_status[ST_RESP_UDF]          = r_resp_udf;
    w_status[ST_CMD_FULL]          = w_cmd_full;
    w_status[ST_RESP_FULL]         = w_resp_full;
  end

  // Read data selection by offset; unmapped offsets read as zero
  always_comb begin
    w_rdata_mux = '0;
    case (w_offset)
      OFF_CTRL:      w_rdata_mux = {28'b0, r_rs_req, 1'b0};
      OFF_EXEC:      w_rdata_mux = {31'b0, r_exec};
      OFF_RF_WE:     w_rdata_mux = {31'b0, r_rf_we};
      OFF_RF_ADDR:   w_rdata_mux = {27'b0, r_rf_addr};
      OFF_RF_WDATA:  w_rdata_mux = r_rf_wdata;
      OFF_FU_ID:     w_rdata_mux = {28'b0, r_fu_id};
      OFF_FU_OPCODE: w_rdata_mux = {24'b0, r_fu_opcode};
      OFF_FU_RS0:    w_rdata_mux = {27'b0, r_fu_rs0};
      OFF_FU_RS1:    w_rdata_mux = {27'b0, r_fu_rs1};
      OFF_FU_RS2:    w_rdata_mux = {27'b0, r_fu_rs2};
      OFF_FU_RD:     w_rdata_mux = {27'b0, r_fu_rd};
      OFF_RDATA:     w_rdata_mux = w_resp_empty ? 32'h0 : w_resp_head;
      OFF_STATUS:    w_rdata_mux = w_status;
      default:       w_rdata_mux = '0;
    endcase
  end

  // Staging register writes, truncated to each field's width
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_exec      <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wdata  <= '0;
      r_fu_id     <= '0;
      r_fu_opcode <= '0;
      r_fu_rs0    <= '0;
      r_fu_rs1    <= '0;
      r_fu_rs2    <= '0;
      r_fu_rd     <= '0;
      r_rs_req    <= '0;
    end else if (w_wr) begin
      case (w_offset)
        OFF_CTRL:      r_rs_req    <= bus_wdata_bi[3:1];
        OFF_EXEC:      r_exec      <= bus_wdata_bi[0];
        OFF_RF_WE:     r_rf_we     <= bus_wdata_bi[0];
        OFF_RF_ADDR:   r_rf_addr   <= bus_wdata_bi[4:0];
        OFF_RF_WDATA:  r_rf_wdata  <= bus_wdata_bi;
        OFF_FU_ID:     r_fu_id     <= bus_wdata_bi[3:0];
        OFF_FU_OPCODE: r_fu_opcode <= bus_wdata_bi[7:0];
        OFF_FU_RS0:    r_fu_rs0    <= bus_wdata_bi[4:0];
        OFF_FU_RS1:    r_fu_rs1    <= bus_wdata_bi[4:0];
        OFF_FU_RS2:    r_fu_rs2    <= bus_wdata_bi[4:0];
        OFF_FU_RD:     r_fu_rd     <= bus_wdata_bi[4:0];
        default:       ;
      endcase
    end
  end

  // Sticky error bits: set by the error event, cleared by write-1 to STATUS_CLR
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cmd_ovf  <= 1'b0;
      r_resp_udf <= 1'b0;
    end else begin
      if (w_cmd_issue && w_cmd_full)
        r_cmd_ovf <= 1'b1;
      else if (w_status_clr && bus_wdata_bi[ST_CMD_OVF])
        r_cmd_ovf <= 1'b0;
      if (w_rdata_rd && w_resp_empty)
        r_resp_udf <= 1'b1;
      else if (w_status_clr && bus_wdata_bi[ST_RESP_UDF])
        r_resp_udf <= 1'b0;
    end
  end

  // One-cycle read response for in-window reads; data is zero when idle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rdata_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_citadel_cmd_bridge.sv
// Directed bench for citadel_cmd_bridge: staging/CTRL issue, CMD FIFO
// overflow, RESP FIFO back-pressure, underflow, address window and reset.
module tb_citadel_cmd_bridge;
  import citadel_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'h10000000;

  logic                      clk;
  logic                      rst_n;
  logic                      bus_req;
  logic                      bus_we;
  logic [31:0]               bus_addr;
  logic [3:0]                bus_be;
  logic [31:0]               bus_wdata;
  logic                      bus_ack;
  logic                      bus_resp;
  logic [31:0]               bus_rdata;
  logic                      cmd_req;
  citadel_gen_cmd_req_struct cmd_wdata;
  logic                      cmd_ack;
  logic                      resp_req;
  logic [31:0]               resp_rdata;
  logic                      resp_ack;

  int checks = 0;
  int errors = 0;

  citadel_cmd_bridge dut (
    .clk_i                     (clk),
    .rst_n_i                   (rst_n),
    .bus_req_i                 (bus_req),
    .bus_we_i                  (bus_we),
    .bus_addr_bi               (bus_addr),
    .bus_be_bi                 (bus_be),
    .bus_wdata_bi              (bus_wdata),
    .bus_ack_o                 (bus_ack),
    .bus_resp_o                (bus_resp),
    .bus_rdata_bo              (bus_rdata),
    .cmd_req_genfifo_req_o     (cmd_req),
    .cmd_req_genfifo_wdata_bo  (cmd_wdata),
    .cmd_req_genfifo_ack_i     (cmd_ack),
    .cmd_resp_genfifo_req_i    (resp_req),
    .cmd_resp_genfifo_rdata_bi (resp_rdata),
    .cmd_resp_genfifo_ack_o    (resp_ack)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one full-word write, request held across one rising edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  // Driver: one read; returns ack during the request and resp/data one cycle later
  task automatic bus_read(input logic [31:0] addr, output logic ack,
                          output logic resp, output logic [31:0] data);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr;
    #1 ack = bus_ack;
    @(negedge clk);
    bus_req = 1'b0;
    resp = bus_resp;
    data = bus_rdata;
  endtask

  // Driver: hold cmd ack until the CMD FIFO empties (bounded), counting beats
  task automatic drain(output int beats);
    beats = 0;
    @(negedge clk);
    cmd_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!cmd_req) break;
      beats++;
      @(negedge clk);
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic a, r;
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %0b exp 0", bus_resp); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus_rdata); end
    checks++; if (cmd_req !== 1'b0) begin errors++; $display("FAIL reset_cmd_req got %0b exp 0", cmd_req); end
    checks++; if (resp_ack !== 1'b1) begin errors++; $display("FAIL reset_resp_ack got %0b exp 1", resp_ack); end
    rst_n = 1'b1;
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0 || r !== 1'b1) begin errors++; $display("FAIL reset_status got %h resp %0b exp 0 resp 1", d, r); end
  endtask

  task automatic test_single_cmd();
    int beats;
    logic a, r;
    logic [31:0] d;
    bus_write(BASE + 32'h18, 32'h5);
    bus_write(BASE + 32'h1C, 32'h7);
    bus_write(BASE + 32'h00, 32'h3);
    checks++; if (cmd_req !== 1'b1) begin errors++; $display("FAIL cmd_req_valid got %0b exp 1", cmd_req); end
    checks++; if (cmd_wdata.fu_opcode !== 8'h05) begin errors++; $display("FAIL cmd_opcode got %h exp 05", cmd_wdata.fu_opcode); end
    checks++; if (cmd_wdata.fu_rs0 !== 5'h07) begin errors++; $display("FAIL cmd_rs0 got %h exp 07", cmd_wdata.fu_rs0); end
    checks++;
    if ({cmd_wdata.fu_rs2_req, cmd_wdata.fu_rs1_req, cmd_wdata.fu_rs0_req} !== 3'b001) begin
      errors++; $display("FAIL cmd_rs_req got %b exp 001",
                         {cmd_wdata.fu_rs2_req, cmd_wdata.fu_rs1_req, cmd_wdata.fu_rs0_req});
    end
    drain(beats);
    checks++; if (beats != 1) begin errors++; $display("FAIL cmd_beats got %0d exp 1", beats); end
    bus_read(BASE + 32'h00, a, r, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ctrl_readback got %h exp 2", d); end
  endtask

  task automatic test_readback();
    logic a, r;
    logic [31:0] d;
    bus_write(BASE + 32'h04, 32'h3);
    bus_read(BASE + 32'h04, a, r, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL exec_trunc got %h exp 1", d); end
    bus_write(BASE + 32'h0C, 32'hFF);
    bus_read(BASE + 32'h0C, a, r, d);
    checks++; if (d !== 32'h1F) begin errors++; $display("FAIL rf_addr_trunc got %h exp 1f", d); end
    bus_write(BASE + 32'h10, 32'hDEADBEEF);
    bus_read(BASE + 32'h10, a, r, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_wdata got %h exp deadbeef", d); end
    bus_write(BASE + 32'h28, 32'h25);
    bus_read(BASE + 32'h28, a, r, d);
    checks++; if (d !== 32'h05) begin errors++; $display("FAIL fu_rd_trunc got %h exp 05", d); end
    bus_write(BASE + 32'h00, 32'hE);
    bus_read(BASE + 32'h00, a, r, d);
    checks++; if (d !== 32'hE) begin errors++; $display("FAIL ctrl_nopush got %h exp e", d); end
    checks++; if (cmd_req !== 1'b0) begin errors++; $display("FAIL ctrl_nopush_req got %0b exp 0", cmd_req); end
  endtask

  task automatic test_cmd_overflow();
    int beats;
    logic a, r;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) bus_write(BASE + 32'h00, 32'h1);
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0005_0004) begin errors++; $display("FAIL ovf_status got %h exp 00050004", d); end
    bus_write(BASE + 32'h48, 32'h10000);
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0004_0004) begin errors++; $display("FAIL ovf_clear got %h exp 00040004", d); end
    // Issue while full with a pop in the same cycle: still dropped
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h1; cmd_ack = 1'b1;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0; cmd_ack = 1'b0;
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0001_0003) begin errors++; $display("FAIL ovf_pop_same_cycle got %h exp 00010003", d); end
    bus_write(BASE + 32'h48, 32'h10000);
    drain(beats);
    checks++; if (beats != 3) begin errors++; $display("FAIL ovf_drain_beats got %0d exp 3", beats); end
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_final_status got %h exp 0", d); end
  endtask

  task automatic test_resp_backpressure();
    logic a, r;
    logic [31:0] d;
    logic [31:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      resp_req = 1'b1; resp_rdata = 32'hA1 + i;
      #1;
      checks++; if (resp_ack !== 1'b1) begin errors++; $display("FAIL resp_ack_fill%0d got %0b exp 1", i, resp_ack); end
    end
    @(negedge clk);
    resp_rdata = 32'hA9;
    #1;
    checks++; if (resp_ack !== 1'b0) begin errors++; $display("FAIL resp_ack_full got %0b exp 0", resp_ack); end
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0008_0800) begin errors++; $display("FAIL resp_full_status got %h exp 00080800", d); end
    bus_read(BASE + 32'h40, a, r, d);
    checks++; if (d !== 32'hA1) begin errors++; $display("FAIL resp_pop0 got %h exp a1", d); end
    checks++; if (resp_ack !== 1'b1) begin errors++; $display("FAIL resp_ack_after_pop got %0b exp 1", resp_ack); end
    @(negedge clk);
    resp_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = 32'hA2 + i;
      bus_read(BASE + 32'h40, a, r, d);
      checks++; if (d !== exp_d || r !== 1'b1) begin errors++; $display("FAIL resp_pop%0d got %h resp %0b exp %h", i + 1, d, r, exp_d); end
    end
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL resp_final_status got %h exp 0", d); end
  endtask

  task automatic test_rdata_underflow();
    logic a, r;
    logic [31:0] d;
    bus_read(BASE + 32'h40, a, r, d);
    checks++; if (r !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL udf_read got %h resp %0b exp 0 resp 1", d, r); end
    checks++; if (bus_resp !== 1'b1) begin errors++; $display("FAIL udf_resp_hold got %0b exp 1", bus_resp); end
    @(negedge clk);
    checks++; if (bus_resp !== 1'b0) begin errors++; $display("FAIL udf_resp_one_cycle got %0b exp 0", bus_resp); end
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL udf_status got %h exp 00020000", d); end
    bus_write(BASE + 32'h48, 32'h20000);
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL udf_clear got %h exp 0", d); end
  endtask

  task automatic test_window();
    logic a, r;
    logic [31:0] d;
    bus_read(32'h10000030, a, r, d);
    checks++; if (a !== 1'b1 || r !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_read ack %0b resp %0b data %h exp 1 1 0", a, r, d); end
    bus_read(32'h20000000, a, r, d);
    checks++; if (a !== 1'b1 || r !== 1'b0) begin errors++; $display("FAIL miss_read ack %0b resp %0b exp 1 0", a, r); end
    @(negedge clk);
    checks++; if (bus_resp !== 1'b0) begin errors++; $display("FAIL miss_no_late_resp got %0b exp 0", bus_resp); end
  endtask

  task automatic test_reset_mid_drain();
    logic a, r;
    logic [31:0] d;
    bus_write(BASE + 32'h18, 32'h9);
    for (int i = 0; i < 3; i++) bus_write(BASE + 32'h00, 32'h1);
    // Start draining and a read, then reset before the read response is seen
    @(negedge clk);
    cmd_ack = 1'b1;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = BASE + 32'h44;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus_req = 1'b0;
    #1;
    checks++; if (cmd_req !== 1'b0) begin errors++; $display("FAIL rst_cmd_req got %0b exp 0", cmd_req); end
    checks++; if (bus_resp !== 1'b0) begin errors++; $display("FAIL rst_pending_resp got %0b exp 0", bus_resp); end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ack = 1'b0;
    bus_read(BASE + 32'h44, a, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", d); end
    bus_read(BASE + 32'h18, a, r, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_staging got %h exp 0", d); end
  endtask

  initial begin
    rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0;
    bus_be = 4'hF; bus_wdata = '0; cmd_ack = 1'b0; resp_req = 1'b0; resp_rdata = '0;
    test_reset();
    test_single_cmd();
    test_readback();
    test_cmd_overflow();
    test_resp_backpressure();
    test_rdata_underflow();
    test_window();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
